// File: rtl/ysyx_25020047_pkg.sv
// rtl/ysyx_25020047_pkg.sv - shared funct3 codes, LSU state encoding and request record
package ysyx_25020047_pkg;

    // Load/store width codes (bit 2 set = zero-extending load)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // LSU FSM states
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Bus request fields captured at accept and held until the bus takes them
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } lsu_req_t;

endpackage

// File: rtl/ysyx_25020047_lsu_align.sv
// rtl/ysyx_25020047_lsu_align.sv - byte-lane alignment for stores and extension for loads
// Ports:
//   i_funct3     width code of the access
//   i_addr_lo    addr[1:0], byte offset inside the word
//   i_is_store   1 for a store; only b/h/w are legal stores and wmask is 0 otherwise
//   i_store_data LSB-aligned store value
//   i_rdata      read word from the bus
//   o_wmask      byte enables (0 for loads)
//   o_wdata      store data moved onto its byte lanes
//   o_ldata      sign/zero-extended load value
//   o_misaligned half on odd address or word not on a word boundary
//   o_bad_funct3 width code not legal for this kind of access
module ysyx_25020047_lsu_align
    import ysyx_25020047_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_is_store,
    input  logic [31:0] i_store_data,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_wmask,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata,
    output logic        o_misaligned,
    output logic        o_bad_funct3
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte  = i_rdata[{i_addr_lo, 3'b000} +: 8];
    // Half loads only reach here aligned, so addr[1] alone picks the lane
    assign w_half  = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
    assign o_wdata = i_store_data << {i_addr_lo, 3'b000};

    always_comb begin
        o_wmask      = 4'b0000;
        o_ldata      = 32'h0;
        o_misaligned = 1'b0;
        o_bad_funct3 = 1'b0;
        case (i_funct3)
            F3_B: begin
                o_wmask = 4'b0001 << i_addr_lo;
                o_ldata = {{24{w_byte[7]}}, w_byte};
            end
            F3_BU: begin
                o_ldata      = {24'h0, w_byte};
                o_bad_funct3 = i_is_store;
            end
            F3_H: begin
                o_wmask      = 4'b0011 << i_addr_lo;
                o_ldata      = {{16{w_half[15]}}, w_half};
                o_misaligned = i_addr_lo[0];
            end
            F3_HU: begin
                o_ldata      = {16'h0, w_half};
                o_misaligned = i_addr_lo[0];
                o_bad_funct3 = i_is_store;
            end
            F3_W: begin
                o_wmask      = 4'b1111;
                o_ldata      = i_rdata;
                o_misaligned = |i_addr_lo;
            end
            default: o_bad_funct3 = 1'b1;
        endcase
        if (!i_is_store) begin
            o_wmask = 4'b0000;
        end
    end

endmodule

// File: rtl/ysyx_25020047_lsu.sv
// rtl/ysyx_25020047_lsu.sv - load/store unit between EXU and WBU, single-outstanding bus
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_in_valid / o_in_ready          op handshake from EXU (ready only in IDLE)
//   i_mem_ren, i_mem_wen             load / store select (both set = load)
//   i_funct3, i_addr, i_store_data   access width, byte address, LSB-aligned store value
//   o_out_valid / i_out_ready        result handshake to WBU
//   o_memdata, o_lsu_err             extended load data and error flag, valid with o_out_valid
//   o_bus_req_valid / i_bus_req_ready, o_bus_we, o_bus_addr, o_bus_wdata, o_bus_wmask
//                                    bus request channel
//   i_bus_rsp_valid, i_bus_rsp_rdata, i_bus_rsp_err
//                                    bus response channel
module ysyx_25020047_lsu
    import ysyx_25020047_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = 9
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic        i_mem_ren,
    input  logic        i_mem_wen,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_store_data,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_memdata,
    output logic        o_lsu_err,
    output logic        o_bus_req_valid,
    input  logic        i_bus_req_ready,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_wmask,
    input  logic        i_bus_rsp_valid,
    input  logic [31:0] i_bus_rsp_rdata,
    input  logic        i_bus_rsp_err
);

    logic [1:0]       r_state;
    lsu_req_t         r_req;
    logic [2:0]       r_funct3;
    logic [1:0]       r_addr_lo;
    logic [31:0]      r_memdata;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic             w_idle;
    logic             w_is_mem;
    logic             w_is_store;
    logic [2:0]       w_fn;
    logic [1:0]       w_lo;
    logic             w_st;
    logic [3:0]       w_wmask;
    logic [31:0]      w_wdata;
    logic [31:0]      w_ldata;
    logic             w_misaligned;
    logic             w_bad_funct3;

    assign w_idle     = (r_state == S_IDLE);
    assign w_is_mem   = i_mem_ren || i_mem_wen;
    // ren&&wen is illegal and resolves to a load
    assign w_is_store = i_mem_wen && !i_mem_ren;

    // One aligner serves both ends: live inputs while accepting in IDLE,
    // the captured width/offset while decoding the response in WAIT.
    assign w_fn = w_idle ? i_funct3    : r_funct3;
    assign w_lo = w_idle ? i_addr[1:0] : r_addr_lo;
    assign w_st = w_idle ? w_is_store  : r_req.we;

    ysyx_25020047_lsu_align u_align (
        .i_funct3     (w_fn),
        .i_addr_lo    (w_lo),
        .i_is_store   (w_st),
        .i_store_data (i_store_data),
        .i_rdata      (i_bus_rsp_rdata),
        .o_wmask      (w_wmask),
        .o_wdata      (w_wdata),
        .o_ldata      (w_ldata),
        .o_misaligned (w_misaligned),
        .o_bad_funct3 (w_bad_funct3)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_req     <= '0;
            r_funct3  <= 3'b000;
            r_addr_lo <= 2'b00;
            r_memdata <= 32'h0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_funct3    <= i_funct3;
                        r_addr_lo   <= i_addr[1:0];
                        r_req.we    <= w_is_store;
                        r_req.addr  <= {i_addr[31:2], 2'b00};
                        r_req.wdata <= w_wdata;
                        r_req.wmask <= w_wmask;
                        r_memdata   <= 32'h0;
                        if (!w_is_mem) begin
                            r_err   <= 1'b0;
                            r_state <= S_DONE;
                        end else if (w_misaligned || w_bad_funct3) begin
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_err   <= 1'b0;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (i_bus_req_ready) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_bus_rsp_valid) begin
                        r_err     <= i_bus_rsp_err;
                        r_memdata <= (i_bus_rsp_err || r_req.we) ? 32'h0 : w_ldata;
                        r_state   <= S_DONE;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // This is the TIMEOUT-th silent cycle in WAIT
                        r_cnt     <= r_cnt + 1'b1;
                        r_err     <= 1'b1;
                        r_memdata <= 32'h0;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready      = w_idle;
    assign o_out_valid     = (r_state == S_DONE);
    assign o_memdata       = r_memdata;
    assign o_lsu_err       = r_err;
    assign o_bus_req_valid = (r_state == S_REQ);
    assign o_bus_we        = r_req.we;
    assign o_bus_addr      = r_req.addr;
    assign o_bus_wdata     = r_req.wdata;
    assign o_bus_wmask     = r_req.wmask;

endmodule

// File: tb/tb_ysyx_25020047_lsu.sv
// tb/tb_ysyx_25020047_lsu.sv - self-checking bench for ysyx_25020047_lsu
module tb_ysyx_25020047_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, mem_ren, mem_wen;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        out_valid, out_ready;
    logic [31:0] memdata;
    logic        lsu_err;
    logic        bus_req_valid, bus_req_ready, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wmask;
    logic        bus_rsp_valid, bus_rsp_err;
    logic [31:0] bus_rsp_rdata;

    always #5 clk = ~clk;

    ysyx_25020047_lsu dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_in_valid      (in_valid),
        .o_in_ready      (in_ready),
        .i_mem_ren       (mem_ren),
        .i_mem_wen       (mem_wen),
        .i_funct3        (funct3),
        .i_addr          (addr),
        .i_store_data    (store_data),
        .o_out_valid     (out_valid),
        .i_out_ready     (out_ready),
        .o_memdata       (memdata),
        .o_lsu_err       (lsu_err),
        .o_bus_req_valid (bus_req_valid),
        .i_bus_req_ready (bus_req_ready),
        .o_bus_we        (bus_we),
        .o_bus_addr      (bus_addr),
        .o_bus_wdata     (bus_wdata),
        .o_bus_wmask     (bus_wmask),
        .i_bus_rsp_valid (bus_rsp_valid),
        .i_bus_rsp_rdata (bus_rsp_rdata),
        .i_bus_rsp_err   (bus_rsp_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    typedef struct {
        logic        ren, wen;
        logic [2:0]  f3;
        logic [31:0] addr, sdata, rdata;
        logic        rsp_err, no_rsp;
        int          req_lat, rsp_lat, out_lat;
        logic        exp_bus;
        logic [31:0] exp_memdata;
        logic        exp_err;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_wdata;
    } vec_t;

    function automatic vec_t mkv(input logic ren, wen, input logic [2:0] f3,
                                 input logic [31:0] a, sd, rd, input logic re, nr,
                                 input int ql, sl, ol, input logic eb,
                                 input logic [31:0] emd, input logic ee,
                                 input logic [3:0] ewm, input logic [31:0] ewd);
        vec_t v;
        v.ren = ren; v.wen = wen; v.f3 = f3; v.addr = a; v.sdata = sd; v.rdata = rd;
        v.rsp_err = re; v.no_rsp = nr; v.req_lat = ql; v.rsp_lat = sl; v.out_lat = ol;
        v.exp_bus = eb; v.exp_memdata = emd; v.exp_err = ee; v.exp_wmask = ewm; v.exp_wdata = ewd;
        return v;
    endfunction

    // Reference model: works from access size and byte offset with plain arithmetic
    function automatic vec_t model(input vec_t v);
        vec_t   r = v;
        int     a = int'(v.addr[1:0]);
        int     size;
        bit     store, mem, legal;
        longint val;
        store = v.wen && !v.ren;
        mem   = v.ren || v.wen;
        case (v.f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        legal = (size != 0) && (!store || v.f3 < 3'd4);
        r.exp_bus = mem && (legal ? ((a % (legal ? size : 1)) == 0) : 1'b0);
        r.exp_err = (mem && !r.exp_bus) || (r.exp_bus && (v.rsp_err || v.no_rsp));
        r.exp_wmask = (r.exp_bus && store) ? 4'(((1 << size) - 1) << a) : 4'b0000;
        r.exp_wdata = 32'(longint'(v.sdata) << (8 * a));
        r.exp_memdata = 32'h0;
        if (r.exp_bus && !store && !r.exp_err) begin
            val = (longint'(v.rdata) >> (8 * a)) % (longint'(1) << (8 * size));
            if (v.f3 < 3'd4 && val >= (longint'(1) << (8 * size - 1)))
                val = val - (longint'(1) << (8 * size));
            r.exp_memdata = 32'(val);
        end
        return r;
    endfunction

    task automatic do_op(input vec_t v, input string tag);
        int          cyc, rq, rs, lat_exp;
        bit          saw, hs, stable, inr_low, hold_ok;
        logic [31:0] c_addr, c_wdata, md;
        logic [3:0]  c_wmask;
        logic        c_we, er;
        chk({tag, " in_ready_idle"}, {31'h0, in_ready}, 32'd1);
        in_valid = 1'b1; mem_ren = v.ren; mem_wen = v.wen; funct3 = v.f3;
        addr = v.addr; store_data = v.sdata; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0; mem_ren = 1'($urandom); mem_wen = 1'($urandom);
        funct3 = 3'($urandom); addr = $urandom; store_data = $urandom;
        cyc = 0; rq = 0; rs = 0; saw = 0; hs = 0; stable = 1; inr_low = 1;
        c_addr = '0; c_wdata = '0; c_wmask = '0; c_we = 1'b0;
        while (!out_valid && cyc < 400) begin
            if (in_ready) inr_low = 0;
            bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
            bus_rsp_rdata = $urandom;
            if (bus_req_valid) begin
                if (!saw) begin
                    saw = 1; c_addr = bus_addr; c_wdata = bus_wdata; c_wmask = bus_wmask; c_we = bus_we;
                end else if (bus_addr !== c_addr || bus_wdata !== c_wdata ||
                             bus_wmask !== c_wmask || bus_we !== c_we) begin
                    stable = 0;
                end
                if (rq >= v.req_lat) bus_req_ready = 1'b1;
                else if ($urandom_range(0, 1) == 1) begin
                    bus_rsp_valid = 1'b1; bus_rsp_err = 1'b1;
                end
                rq++;
            end else if (hs && !v.no_rsp) begin
                if (rs >= v.rsp_lat) begin
                    bus_rsp_valid = 1'b1; bus_rsp_rdata = v.rdata; bus_rsp_err = v.rsp_err;
                end
                rs++;
            end
            @(posedge clk); #1;
            if (bus_req_ready) hs = 1;
            cyc++;
        end
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
        lat_exp = !v.exp_bus ? 1 : (v.no_rsp ? 2 + v.req_lat + 256 : 3 + v.req_lat + v.rsp_lat);
        chk({tag, " latency"}, 32'(cyc + 1), 32'(lat_exp));
        chk({tag, " bus_used"}, {31'h0, saw}, {31'h0, v.exp_bus});
        chk({tag, " in_ready_busy"}, {31'h0, inr_low}, 32'd1);
        if (v.exp_bus) begin
            chk({tag, " bus_addr"}, c_addr, {v.addr[31:2], 2'b00});
            chk({tag, " bus_wmask"}, {28'h0, c_wmask}, {28'h0, v.exp_wmask});
            chk({tag, " bus_we"}, {31'h0, c_we}, {31'h0, v.wen && !v.ren});
            chk({tag, " req_stable"}, {31'h0, stable}, 32'd1);
            if (v.wen && !v.ren) chk({tag, " bus_wdata"}, c_wdata, v.exp_wdata);
        end
        chk({tag, " memdata"}, memdata, v.exp_memdata);
        chk({tag, " lsu_err"}, {31'h0, lsu_err}, {31'h0, v.exp_err});
        md = memdata; er = lsu_err; hold_ok = 1;
        for (int k = 0; k < v.out_lat; k++) begin
            bus_rsp_valid = 1'($urandom); bus_rsp_rdata = $urandom; bus_rsp_err = 1'($urandom);
            @(posedge clk); #1;
            if (!out_valid || in_ready || memdata !== md || lsu_err !== er) hold_ok = 0;
        end
        bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
        if (v.out_lat > 0) chk({tag, " hold"}, {31'h0, hold_ok}, 32'd1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, " release"}, {30'h0, in_ready, out_valid}, 32'b10);
    endtask

    vec_t tbl[17];
    vec_t rv;

    initial begin
        rst = 1'b1; in_valid = 0; mem_ren = 0; mem_wen = 0; funct3 = 0; addr = 0; store_data = 0;
        out_ready = 0; bus_req_ready = 0; bus_rsp_valid = 0; bus_rsp_rdata = 0; bus_rsp_err = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset in_ready", {31'h0, in_ready}, 32'd1);
        chk("reset out_valid", {31'h0, out_valid}, 32'd0);
        chk("reset req_valid", {31'h0, bus_req_valid}, 32'd0);
        chk("reset memdata", memdata, 32'h0);
        chk("reset lsu_err", {31'h0, lsu_err}, 32'd0);
        chk("reset bus_we", {31'h0, bus_we}, 32'd0);
        chk("reset bus_addr", bus_addr, 32'h0);
        chk("reset bus_wdata", bus_wdata, 32'h0);
        chk("reset bus_wmask", {28'h0, bus_wmask}, 32'h0);

        //              ren wen f3    addr          sdata         rdata         re nr ql sl ol bus memdata       err wmask    wdata
        tbl[0]  = mkv(1, 0, 3'd0, 32'h8000_0003, 32'h0,        32'h80FF_1234, 0, 0, 0, 0, 0, 1, 32'hFFFF_FF80, 0, 4'b0000, 32'h0);
        tbl[1]  = mkv(0, 1, 3'd1, 32'h8000_0002, 32'h0000_ABCD, 32'h0,        0, 0, 0, 0, 0, 1, 32'h0,         0, 4'b1100, 32'hABCD_0000);
        tbl[2]  = mkv(1, 0, 3'd2, 32'h8000_0001, 32'h0,        32'h0,         0, 0, 0, 0, 0, 0, 32'h0,         1, 4'b0000, 32'h0);
        tbl[3]  = mkv(1, 0, 3'd5, 32'h8000_0002, 32'h0,        32'hBEEF_0000, 0, 0, 5, 3, 2, 1, 32'h0000_BEEF, 0, 4'b0000, 32'h0);
        tbl[4]  = mkv(1, 0, 3'd1, 32'h8000_0002, 32'h0,        32'h8001_0000, 0, 0, 1, 0, 0, 1, 32'hFFFF_8001, 0, 4'b0000, 32'h0);
        tbl[5]  = mkv(1, 0, 3'd4, 32'h8000_0001, 32'h0,        32'h0000_F300, 0, 0, 0, 2, 1, 1, 32'h0000_00F3, 0, 4'b0000, 32'h0);
        tbl[6]  = mkv(0, 1, 3'd0, 32'h0000_1003, 32'h1234_5678, 32'h0,        0, 0, 2, 0, 0, 1, 32'h0,         0, 4'b1000, 32'h7800_0000);
        tbl[7]  = mkv(0, 1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        0, 0, 0, 1, 0, 1, 32'h0,         0, 4'b1111, 32'hDEAD_BEEF);
        tbl[8]  = mkv(0, 0, 3'd2, 32'h0000_0013, 32'h5555_5555, 32'h0,        0, 0, 0, 0, 1, 0, 32'h0,         0, 4'b0000, 32'h0);
        tbl[9]  = mkv(1, 0, 3'd2, 32'h0000_0020, 32'h0,        32'h1234_5678, 1, 0, 0, 0, 0, 1, 32'h0,         1, 4'b0000, 32'h0);
        tbl[10] = mkv(1, 0, 3'd3, 32'h0000_0000, 32'h0,        32'h0,         0, 0, 0, 0, 0, 0, 32'h0,         1, 4'b0000, 32'h0);
        tbl[11] = mkv(1, 1, 3'd2, 32'h0000_0040, 32'h1111_1111, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D, 0, 4'b0000, 32'h0);
        tbl[12] = mkv(0, 1, 3'd1, 32'h0000_0001, 32'h0000_1234, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0,         1, 4'b0000, 32'h0);
        tbl[13] = mkv(1, 0, 3'd2, 32'h0000_0080, 32'h0,        32'h0,         0, 1, 0, 0, 1, 1, 32'h0,         1, 4'b0000, 32'h0);
        tbl[14] = mkv(1, 0, 3'd0, 32'h0000_0000, 32'h0,        32'h0000_007F, 0, 0, 0, 0, 0, 1, 32'h0000_007F, 0, 4'b0000, 32'h0);
        tbl[15] = mkv(1, 0, 3'd5, 32'h0000_0003, 32'h0,        32'h0,         0, 0, 0, 0, 0, 0, 32'h0,         1, 4'b0000, 32'h0);
        tbl[16] = mkv(0, 1, 3'd0, 32'h0000_0002, 32'h0000_00AA, 32'h0,        1, 0, 0, 0, 0, 1, 32'h0,         1, 4'b0100, 32'h00AA_0000);

        for (int i = 0; i < 17; i++) do_op(tbl[i], $sformatf("vec%0d", i));

        // Reset while waiting for a response: abort to IDLE, late response dropped
        in_valid = 1'b1; mem_ren = 1'b1; mem_wen = 1'b0; funct3 = 3'd2; addr = 32'h100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst_seq req_valid", {31'h0, bus_req_valid}, 32'd1);
        bus_req_ready = 1'b1;
        @(posedge clk); #1;
        bus_req_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seq waiting", {30'h0, in_ready, out_valid}, 32'b00);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_seq idle", {29'h0, in_ready, out_valid, bus_req_valid}, 32'b100);
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'hFFFF_FFFF; bus_rsp_err = 1'b1;
        @(posedge clk); #1;
        bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
        chk("rst_seq late_rsp", {30'h0, in_ready, out_valid}, 32'b10);
        chk("rst_seq memdata", memdata, 32'h0);

        // Randomized ops against the reference model
        for (int i = 0; i < 60; i++) begin
            int pick;
            rv.ren = 1'($urandom); rv.wen = 1'($urandom);
            pick = $urandom_range(0, 7);
            case (pick)
                0: rv.f3 = 3'd0; 1: rv.f3 = 3'd1; 2: rv.f3 = 3'd2; 3: rv.f3 = 3'd4;
                4: rv.f3 = 3'd5; 5: rv.f3 = 3'd2; 6: rv.f3 = 3'd0; default: rv.f3 = 3'($urandom);
            endcase
            rv.addr = $urandom; rv.sdata = $urandom; rv.rdata = $urandom;
            rv.rsp_err = ($urandom_range(0, 7) == 0); rv.no_rsp = 1'b0;
            rv.req_lat = $urandom_range(0, 3); rv.rsp_lat = $urandom_range(0, 3);
            rv.out_lat = $urandom_range(0, 2);
            do_op(model(rv), $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
